// File: rtl/mnet_router_pkg.sv
// Shared definitions for the data-router stride line-buffer writer.
//  - feeder_state_e : row_stride_feeder FSM encoding
//  - DEF_*          : default element width, row length and group depth
package mnet_router_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_BUFW   = 32;
  localparam int DEF_STRIDE = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WIN,
    FIN
  } feeder_state_e;

endpackage

// File: rtl/row_push_pipe.sv
// Two-stage push pipe between the row SRAM and the line buffer.
//  Stage p0 tracks which cycle's SRAM output belongs to a slot (and whether
//  that slot is padding). Stage p1 registers the push strobe and the row,
//  substituting an all-zero row for pad slots.
// Ports:
//  clk, rst_n   clock / asynchronous active-low reset
//  slot_vld_i   a slot is issued this cycle (read or pad)
//  slot_pad_i   the issued slot is padding (no SRAM read behind it)
//  rd_data_i    SRAM row, valid one cycle after the slot
//  vld_p0_o     a slot is in flight in stage p0
//  push_o       push strobe to the line buffer
//  data_o       row pushed into the line buffer
module row_push_pipe #(
  parameter int DW   = 32,
  parameter int BUFW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slot_vld_i,
  input  logic               slot_pad_i,
  input  logic [DW*BUFW-1:0] rd_data_i,
  output logic               vld_p0_o,
  output logic               push_o,
  output logic [DW*BUFW-1:0] data_o
);

  logic               vld_p0_q;
  logic               pad_p0_q;
  logic               push_p1_q;
  logic [DW*BUFW-1:0] data_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      pad_p0_q  <= 1'b0;
      push_p1_q <= 1'b0;
      data_p1_q <= '0;
    end else begin
      // p0: slot issued last cycle, SRAM data arriving now
      vld_p0_q  <= slot_vld_i;
      pad_p0_q  <= slot_pad_i;
      // p1: registered push toward the line buffer
      push_p1_q <= vld_p0_q;
      data_p1_q <= (vld_p0_q && !pad_p0_q) ? rd_data_i : '0;
    end
  end

  assign vld_p0_o = vld_p0_q;
  assign push_o   = push_p1_q;
  assign data_o   = data_p1_q;

endmodule

// File: rtl/row_stride_feeder.sv
// Writer side of the stride line buffer. Reads a frame of rows from the row
// SRAM, pushes them STRIDE per group into the line buffer (padding the last
// group with zero rows), then raises win_valid until the consumer takes it.
// Ports:
//  clk, rst_n             clock / asynchronous active-low reset
//  start                  frame start pulse, honoured only in IDLE
//  base_addr, num_rows    frame descriptor, latched on start
//  mem_rd_en, mem_addr    row SRAM read port
//  mem_rd_data            SRAM row, one cycle after mem_rd_en
//  fifo_read, o_data      push strobe and row to the line buffer
//  win_valid, win_ready   window handshake with the consumer
//  busy, done             frame status
module row_stride_feeder
  import mnet_router_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int STRIDE = DEF_STRIDE,
  parameter int BUFW   = DEF_BUFW,
  parameter int AW     = 10,
  parameter int RW     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic [RW-1:0]      num_rows,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW*BUFW-1:0] mem_rd_data,
  output logic               fifo_read,
  output logic [DW*BUFW-1:0] o_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               busy,
  output logic               done
);

  localparam int SLOT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(STRIDE - 1);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [RW-1:0] nrows_q, nrows_d;
  // One bit wider than num_rows so the padded tail of a maximal frame fits.
  logic [RW:0]   rd_cnt_q, rd_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic rows_left;
  logic pipe_vld_p0;

  assign rows_left = (rd_cnt_q < {1'b0, nrows_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      nrows_q  <= '0;
      rd_cnt_q <= '0;
      slot_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      nrows_q  <= nrows_d;
      rd_cnt_q <= rd_cnt_d;
      slot_q   <= slot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    nrows_d  = nrows_q;
    rd_cnt_d = rd_cnt_q;
    slot_d   = slot_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          nrows_d  = num_rows;
          rd_cnt_d = '0;
          slot_d   = '0;
          busy_d   = 1'b1;
          state_d  = (num_rows == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        // Every slot advances rd_cnt, pad slots included, so a partial
        // last group leaves rd_cnt >= num_rows and the frame ends.
        rd_cnt_d = rd_cnt_q + (RW+1)'(1);
        if (slot_q == LAST_SLOT) begin
          slot_d  = '0;
          state_d = DRAIN;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      DRAIN: begin
        // Last push of the group is on the output and nothing is behind it.
        if (fifo_read && !pipe_vld_p0) state_d = WIN;
      end
      WIN: begin
        if (win_ready) state_d = rows_left ? FETCH : FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en = (state_q == FETCH) && rows_left;
  assign mem_addr  = mem_rd_en ? (base_q + AW'(rd_cnt_q)) : '0;
  assign win_valid = (state_q == WIN);
  assign busy      = busy_q;
  assign done      = done_q;

  row_push_pipe #(
    .DW   (DW),
    .BUFW (BUFW)
  ) u_push_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_vld_i (state_q == FETCH),
    .slot_pad_i (!rows_left),
    .rd_data_i  (mem_rd_data),
    .vld_p0_o   (pipe_vld_p0),
    .push_o     (fifo_read),
    .data_o     (o_data)
  );

endmodule

// File: tb/tb_row_stride_feeder.sv
module tb_row_stride_feeder;

  localparam int DW     = 32;
  localparam int STRIDE = 2;
  localparam int BUFW   = 32;
  localparam int AW     = 10;
  localparam int RW     = 10;
  localparam int ROWW   = DW * BUFW;

  typedef logic [ROWW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [RW-1:0] num_rows = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  row_t          mem_rd_data = '0;
  logic          fifo_read;
  row_t          o_data;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  row_stride_feeder #(
    .DW(DW), .STRIDE(STRIDE), .BUFW(BUFW), .AW(AW), .RW(RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .fifo_read   (fifo_read),
    .o_data      (o_data),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .busy        (busy),
    .done        (done)
  );

  function automatic row_t row_of(input logic [AW-1:0] a);
    row_t r;
    for (int j = 0; j < BUFW; j++) r[j*DW +: DW] = {a, 6'h2A, 16'(j)};
    return r;
  endfunction

  // Row SRAM: one-cycle read latency, junk when not read.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? row_of(mem_addr) : {BUFW{32'hDEADBEEF}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input row_t obs, input row_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Scoreboard queues, filled when a frame is launched.
  logic [AW-1:0] exp_addr_q[$];
  row_t          exp_row_q[$];

  // Monitor state (written only here).
  int   n_rd = 0, n_push = 0, n_win = 0, n_done = 0, n_ovl = 0;
  logic win_d = 1'b0;
  row_t lb_old = '0, lb_new = '0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      n_rd <= n_rd + 1;
      chk("rd_addr", 64'(mem_addr),
          (exp_addr_q.size() != 0) ? 64'(exp_addr_q.pop_front()) : {64{1'b1}});
    end
    if (fifo_read) begin
      n_push <= n_push + 1;
      chk_row("push_row", o_data, (exp_row_q.size() != 0) ? exp_row_q.pop_front() : 'x);
      lb_old <= lb_new;
      lb_new <= o_data;
    end
    win_d <= win_valid;
    if (win_valid && !win_d) n_win <= n_win + 1;
    if (win_valid && (fifo_read || mem_rd_en)) n_ovl <= n_ovl + 1;
    if (done) n_done <= n_done + 1;
  end

  int s_rd, s_push, s_win, s_done, s_ovl;

  task automatic snap();
    s_rd = n_rd; s_push = n_push; s_win = n_win; s_done = n_done; s_ovl = n_ovl;
  endtask

  task automatic expect_frame(input logic [AW-1:0] b, input int n);
    int groups;
    groups = (n + STRIDE - 1) / STRIDE;
    for (int i = 0; i < groups * STRIDE; i++) begin
      if (i < n) begin
        exp_addr_q.push_back(b + AW'(i));
        exp_row_q.push_back(row_of(b + AW'(i)));
      end else begin
        exp_row_q.push_back('0);
      end
    end
  endtask

  // Returns at the negedge of cycle 1 (start sampled at the end of cycle 0).
  task automatic pulse_start(input logic [AW-1:0] b, input int n);
    expect_frame(b, n);
    @(negedge clk);
    base_addr = b;
    num_rows  = RW'(n);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_counts(input string t, input int rd, input int push,
                              input int win, input int dn);
    repeat (3) @(negedge clk);
    chk({t, "_reads"},   64'(n_rd - s_rd), 64'(rd));
    chk({t, "_pushes"},  64'(n_push - s_push), 64'(push));
    chk({t, "_windows"}, 64'(n_win - s_win), 64'(win));
    chk({t, "_dones"},   64'(n_done - s_done), 64'(dn));
    chk({t, "_overlap"}, 64'(n_ovl - s_ovl), 64'd0);
    chk({t, "_sb_left"}, 64'(exp_addr_q.size() + exp_row_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int bad;

    // Reset state
    #1;
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_push", 64'(fifo_read), 64'd0);
    chk("rst_win", 64'(win_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_row("rst_odata", o_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full frame of 4 rows, consumer always ready
    snap();
    pulse_start(10'h010, 4);
    chk("t1_rd_en_c1", 64'(mem_rd_en), 64'd1);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_push_c3", 64'(fifo_read), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_win_c5", 64'(win_valid), 64'd1);
    wait_done(5, lat);
    chk("t1_done_lat", 64'(lat), 64'd12);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    check_counts("t1", 4, 4, 2, 1);
    chk_row("t1_lb_old", lb_old, row_of(10'h012));
    chk_row("t1_lb_new", lb_new, row_of(10'h013));

    // 2: three rows, last group padded with a zero row
    snap();
    pulse_start(10'h010, 3);
    wait_done(1, lat);
    chk("t2_done_lat", 64'(lat), 64'd12);
    check_counts("t2", 3, 4, 2, 1);
    chk_row("t2_lb_new_zero", lb_new, '0);

    // 3: empty frame
    snap();
    pulse_start(10'h010, 0);
    wait_done(1, lat);
    chk("t3_done_lat", 64'(lat), 64'd2);
    check_counts("t3", 0, 0, 0, 1);

    // 4: consumer stalls the first window for 20 cycles
    snap();
    win_ready = 1'b0;
    pulse_start(10'h020, 4);
    lat = 1;
    while (!win_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_win_lat", 64'(lat), 64'd5);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!win_valid || fifo_read || mem_rd_en) bad++;
    end
    chk("t4_hold_bad", 64'(bad), 64'd0);
    win_ready = 1'b1;
    wait_done(lat + 20, lat);
    chk("t4_done_lat", 64'(lat), 64'd32);
    check_counts("t4", 4, 4, 2, 1);

    // 5: address wrap at the top of SRAM
    snap();
    pulse_start(10'h3FF, 2);
    wait_done(1, lat);
    chk("t5_done_lat", 64'(lat), 64'd7);
    check_counts("t5", 2, 2, 1, 1);

    // 6: reset in the middle of FETCH, then a clean frame
    pulse_start(10'h040, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t6_addr", 64'(mem_addr), 64'd0);
    chk("t6_push", 64'(fifo_read), 64'd0);
    chk("t6_win", 64'(win_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk_row("t6_odata", o_data, '0);
    exp_addr_q.delete();
    exp_row_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    pulse_start(10'h050, 4);
    wait_done(1, lat);
    chk("t6_done_lat", 64'(lat), 64'd12);
    check_counts("t6", 4, 4, 2, 1);
    chk_row("t6_lb_new", lb_new, row_of(10'h053));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
